mix_column_arbiter: RTL and testbench
=====================================

# mix_column_arbiter

Shares one MixColumn datapath between two requesters (channel A and channel B of the transmitter's AES engines) through valid/ready handshakes. Each accepted request is arbitrated round-robin, pushed through MixColumn (or bypassed for the final AES round), and registered into a one-entry output stage with its tag and source ID. The block sits between the per-channel round sequencers and the AddRoundKey stage, and keeps per-channel transfer counters for link diagnostics.

## Interface
- TAG_W, 4, width of the request/response tag.
- CNT_W, 16, width of the per-channel accepted-transfer counters.

- Clk  in  1  clock; all state updates on the rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- AValid  in  1  channel A request valid.
- AReady  out  1  channel A request accepted this cycle when AValid & AReady.
- AState  in  128  channel A state, same byte/column order as MixColumn.
- ABypass  in  1  1 = pass AState unmodified (final round).
- ATag  in  TAG_W  channel A tag, returned with the response.
- BValid, BReady, BState, BBypass, BTag: same as the A ports, for channel B.
- RspValid  out  1  response register holds valid data.
- RspReady  in  1  downstream accepts the response when RspValid & RspReady.
- RspState  out  128  MixColumn(state), or state if bypassed.
- RspTag  out  TAG_W  tag of the granted request.
- RspSrc  out  1  0 = channel A, 1 = channel B.
- CntClr  in  1  synchronous clear of both counters.
- CntA, CntB  out  CNT_W  accepted-transfer counts per channel, wrapping.

## Operation
- Instantiates MixColumn once, combinationally, on the granted request's state.
- Slot free: Free = ~RspValid | RspReady.
- Grant, combinational:
  - only A valid → A; only B valid → B.
  - both valid → the channel not granted last (pointer LastB).
  - none valid → no grant.
- AReady = Free & grant==A; BReady = Free & grant==B. At most one Ready high per cycle.
- Ready never depends combinationally on its own Valid beyond the grant; requesters hold Valid, State, Bypass and Tag stable until accepted.
- On an accept:
  - RspState ← Bypass ? State : MixColumn(State).
  - RspTag ← Tag; RspSrc ← granted ID; RspValid ← 1.
  - LastB ← granted ID.
- Response drained (RspValid & RspReady) with no accept → RspValid ← 0; data registers hold.
- Drain and accept in the same cycle → the new response replaces the old one; RspValid stays 1.
- Output stalled (RspValid & ~RspReady): both Ready low; the response register and LastB hold.
- Counters:
  - CntA/CntB increment by 1 per channel accept and wrap from 2^CNT_W-1 to 0.
  - CntClr has priority: the counter reads 0 next cycle even if an accept occurs the same cycle.

## Timing
- Latency: request accepted at edge N → RspValid = 1 after edge N, with data valid in the same cycle.
- Throughput: 1 transfer per cycle when RspReady is held high. Two continuously valid channels alternate A, B, A, B.
- Reset (Rst_n low, asynchronous, any cycle, including mid-transfer):
  - RspValid = 0, RspState = 0, RspTag = 0, RspSrc = 0, CntA = CntB = 0.
  - LastB = 1, so A wins the first contended grant.
  - AReady and BReady are low while in reset.
- An in-flight response is discarded at reset; requesters must re-issue.
- Deassertion of Rst_n is synchronised externally. The first accept is possible on the first edge after release.

## Test plan
- Single A transfer, ABypass = 0, AState = db135345_f20a225c_01010101_c6c6c6c6, ATag = 3, RspReady = 1 → one cycle later RspState = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, RspTag = 3, RspSrc = 0, CntA = 1.
- Bypass on channel B, BState = 00112233_44556677_8899aabb_ccddeeff, BBypass = 1 → RspState equals BState exactly, RspSrc = 1, CntB = 1.
- A and B both valid for 6 cycles after reset, RspReady = 1 → grant order A,B,A,B,A,B; CntA = 3, CntB = 3; exactly one Ready high per cycle.
- Backpressure: RspReady = 0 for 4 cycles with a response held and both requesters valid → AReady = BReady = 0 and RspState/RspTag stable. RspReady = 1 → the next grant is issued in the same cycle, with back-to-back responses.
- Rst_n pulled low while RspValid = 1 and CntA = 5 → asynchronously RspValid = 0 and CntA = 0; after release with both valid, A is granted first.
- Counter wrap and clear, CNT_W = 4: 16 A accepts → CntA wraps to 0. CntClr asserted together with a B accept → CntB = 0 next cycle.

Source files
------------

// File: rtl/mix_column_arbiter.sv
// mix_column_arbiter
//   Shares one combinational AES MixColumns datapath between two requesters
//   (channel A, channel B). Requests are granted round-robin when both are
//   valid. The granted state is mixed (or bypassed for the final round) and
//   captured in a one-entry response register along with its tag and source.
//   Per-channel accept counters are kept for link diagnostics.
//
// Ports
//   Clk, Rst_n                  clock, asynchronous active-low reset
//   AValid/AReady/AState/       channel A request handshake, 128-bit state,
//     ABypass/ATag                bypass flag (final round) and tag
//   BValid/.../BTag             same for channel B
//   RspValid/RspReady           response handshake
//   RspState/RspTag/RspSrc      mixed (or bypassed) state, tag, 0=A 1=B
//   CntClr                      synchronous clear of both counters
//   CntA/CntB                   wrapping accept counters
module mix_column_arbiter #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             AValid,
  output logic             AReady,
  input  logic [127:0]     AState,
  input  logic             ABypass,
  input  logic [TAG_W-1:0] ATag,
  input  logic             BValid,
  output logic             BReady,
  input  logic [127:0]     BState,
  input  logic             BBypass,
  input  logic [TAG_W-1:0] BTag,
  output logic             RspValid,
  input  logic             RspReady,
  output logic [127:0]     RspState,
  output logic [TAG_W-1:0] RspTag,
  output logic             RspSrc,
  input  logic             CntClr,
  output logic [CNT_W-1:0] CntA,
  output logic [CNT_W-1:0] CntB
);

  // GF(2^8) multiply by 2 with the AES polynomial.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column; byte 0 sits in the most significant byte.
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  logic             rsp_valid_q, rsp_valid_d;
  logic [127:0]     rsp_state_q, rsp_state_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_src_q, rsp_src_d;
  logic             last_b_q, last_b_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

  logic             free;
  logic             any_vld;
  logic             gnt_b;
  logic             accept;
  logic [127:0]     sel_state;
  logic             sel_bypass;
  logic [TAG_W-1:0] sel_tag;
  logic [127:0]     mixed;

  // Slot is free when empty or being drained this cycle.
  assign free    = ~rsp_valid_q | RspReady;
  assign any_vld = AValid | BValid;
  // B wins when alone, or when contended and A was granted last.
  assign gnt_b   = BValid & (~AValid | ~last_b_q);

  // Ready is masked during reset: the cleared response register would
  // otherwise make the slot look free.
  assign AReady  = Rst_n & free & AValid & ~gnt_b;
  assign BReady  = Rst_n & free & gnt_b;
  assign accept  = AReady | BReady;

  assign sel_state  = gnt_b ? BState  : AState;
  assign sel_bypass = gnt_b ? BBypass : ABypass;
  assign sel_tag    = gnt_b ? BTag    : ATag;

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign mixed[c*32 +: 32] = mix_col(sel_state[c*32 +: 32]);
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_state_d = rsp_state_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_src_d   = rsp_src_q;
    last_b_d    = last_b_q;
    cnt_a_d     = cnt_a_q;
    cnt_b_d     = cnt_b_q;

    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_state_d = sel_bypass ? sel_state : mixed;
      rsp_tag_d   = sel_tag;
      rsp_src_d   = gnt_b;
      last_b_d    = gnt_b;
      if (gnt_b) cnt_b_d = cnt_b_q + 1'b1;
      else       cnt_a_d = cnt_a_q + 1'b1;
    end else if (rsp_valid_q && RspReady) begin
      rsp_valid_d = 1'b0;
    end

    if (CntClr) begin
      cnt_a_d = '0;
      cnt_b_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_state_q <= '0;
      rsp_tag_q   <= '0;
      rsp_src_q   <= 1'b0;
      last_b_q    <= 1'b1;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_state_q <= rsp_state_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_src_q   <= rsp_src_d;
      last_b_q    <= last_b_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
    end
  end

  assign RspValid = rsp_valid_q;
  assign RspState = rsp_state_q;
  assign RspTag   = rsp_tag_q;
  assign RspSrc   = rsp_src_q;
  assign CntA     = cnt_a_q;
  assign CntB     = cnt_b_q;

  // Unused-in-path guard: any_vld documents the grant condition.
  logic unused_ok;
  assign unused_ok = any_vld;

endmodule

// File: tb/tb_mix_column_arbiter.sv
// Directed bench for mix_column_arbiter (TAG_W=4, CNT_W=4 so wrap is reachable).
module tb_mix_column_arbiter;
  localparam int TAG_W = 4;
  localparam int CNT_W = 4;

  logic             Clk = 1'b0;
  logic             Rst_n;
  logic             AValid, ABypass, BValid, BBypass;
  logic [127:0]     AState, BState;
  logic [TAG_W-1:0] ATag, BTag;
  logic             AReady, BReady;
  logic             RspValid, RspReady, RspSrc, CntClr;
  logic [127:0]     RspState;
  logic [TAG_W-1:0] RspTag;
  logic [CNT_W-1:0] CntA, CntB;

  int nerr = 0;
  int nchk = 0;

  localparam logic [127:0] V1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] V2_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] BP_IN  = 128'h00112233_44556677_8899aabb_ccddeeff;

  mix_column_arbiter #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .AValid(AValid), .AReady(AReady), .AState(AState), .ABypass(ABypass), .ATag(ATag),
    .BValid(BValid), .BReady(BReady), .BState(BState), .BBypass(BBypass), .BTag(BTag),
    .RspValid(RspValid), .RspReady(RspReady), .RspState(RspState), .RspTag(RspTag),
    .RspSrc(RspSrc), .CntClr(CntClr), .CntA(CntA), .CntB(CntB)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst_n = 1'b0; AValid = 1'b1; BValid = 1'b0; ABypass = 1'b0; BBypass = 1'b0;
    AState = '0; BState = '0; ATag = '0; BTag = '0; RspReady = 1'b0; CntClr = 1'b0;

    // Reset state
    #3;
    chk("rst_valid", RspValid, 0);
    chk("rst_state", RspState, 0);
    chk("rst_cnta",  CntA, 0);
    chk("rst_cntb",  CntB, 0);
    chk("rst_aready", AReady, 0);
    AValid = 1'b0;
    #9 Rst_n = 1'b1;

    // Single A transfer through MixColumns
    tick();
    AValid = 1'b1; AState = V1_IN; ATag = 4'd3; RspReady = 1'b1;
    #1;
    chk("t1_aready", AReady, 1);
    chk("t1_bready", BReady, 0);
    tick();
    AValid = 1'b0;
    chk("t1_valid", RspValid, 1);
    chk("t1_state", RspState, V1_OUT);
    chk("t1_tag",   RspTag, 3);
    chk("t1_src",   RspSrc, 0);
    chk("t1_cnta",  CntA, 1);

    // Bypass on B, accepted while the previous response drains
    BValid = 1'b1; BBypass = 1'b1; BState = BP_IN; BTag = 4'd5;
    tick();
    BValid = 1'b0;
    chk("byp_valid", RspValid, 1);
    chk("byp_state", RspState, BP_IN);
    chk("byp_src",   RspSrc, 1);
    chk("byp_tag",   RspTag, 5);
    chk("byp_cntb",  CntB, 1);
    tick();
    chk("drain_valid", RspValid, 0);
    chk("drain_hold",  RspState, BP_IN);

    // Contention: last grant was B, so A,B,A,B,A,B
    AValid = 1'b1; AState = V2_IN; ATag = 4'd1; ABypass = 1'b0;
    BValid = 1'b1; BState = BP_IN; BTag = 4'd2; BBypass = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("alt%0d_aready", i), AReady, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("alt%0d_bready", i), BReady, (i % 2 == 0) ? 0 : 1);
      tick();
      chk($sformatf("alt%0d_src", i), RspSrc, (i % 2 == 0) ? 0 : 1);
      chk($sformatf("alt%0d_state", i), RspState, (i % 2 == 0) ? V2_OUT : BP_IN);
    end
    chk("alt_cnta", CntA, 4);
    chk("alt_cntb", CntB, 4);

    // Backpressure: response from B held for 4 cycles
    RspReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("bp%0d_aready", i), AReady, 0);
      chk($sformatf("bp%0d_bready", i), BReady, 0);
      tick();
      chk($sformatf("bp%0d_state", i), RspState, BP_IN);
      chk($sformatf("bp%0d_tag", i), RspTag, 2);
      chk($sformatf("bp%0d_valid", i), RspValid, 1);
    end
    chk("bp_cnta", CntA, 4);
    RspReady = 1'b1;
    #1;
    chk("bp_rel_aready", AReady, 1);
    tick();
    chk("bp_rel_src0",   RspSrc, 0);
    chk("bp_rel_state0", RspState, V2_OUT);
    chk("bp_rel_tag0",   RspTag, 1);
    #1;
    chk("bp_rel_bready", BReady, 1);
    tick();
    chk("bp_rel_src1",   RspSrc, 1);
    chk("bp_rel_valid1", RspValid, 1);
    chk("pre_rst_cnta",  CntA, 5);

    // Asynchronous reset mid-cycle with a response held
    AValid = 1'b0; BValid = 1'b0; RspReady = 1'b0;
    #1 Rst_n = 1'b0;
    #1;
    chk("arst_valid", RspValid, 0);
    chk("arst_cnta",  CntA, 0);
    chk("arst_cntb",  CntB, 0);
    chk("arst_state", RspState, 0);
    chk("arst_tag",   RspTag, 0);
    chk("arst_src",   RspSrc, 0);
    AValid = 1'b1; BValid = 1'b1; RspReady = 1'b1;
    #1;
    chk("arst_aready", AReady, 0);
    chk("arst_bready", BReady, 0);
    #1 Rst_n = 1'b1;
    #1;
    chk("post_rst_aready", AReady, 1);
    chk("post_rst_bready", BReady, 0);
    tick();
    chk("post_rst_src",  RspSrc, 0);
    chk("post_rst_cnta", CntA, 1);

    // Counter wrap on A (CNT_W=4)
    BValid = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("wrap_cnta15", CntA, 15);
    tick();
    chk("wrap_cnta0", CntA, 0);
    AValid = 1'b0;

    // Clear wins over a simultaneous B accept
    BValid = 1'b1; CntClr = 1'b1;
    tick();
    CntClr = 1'b0;
    chk("clr_cntb", CntB, 0);
    chk("clr_src",  RspSrc, 1);
    chk("clr_valid", RspValid, 1);
    tick();
    BValid = 1'b0;
    chk("clr_cntb_inc", CntB, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
